// File: rtl/spi_pkg.sv
// Shared SPI definitions: transfer FSM state encoding, default word width
// and the mode-0 clock polarity/phase constants.
package spi_pkg;

  localparam int SPI_DATA_W = 8;

  // Only mode 0 is implemented; these are kept for future mode support.
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    SHIFT = 3'd2,
    TRAIL = 3'd3,
    DONE  = 3'd4
  } xfer_state_e;

endpackage

// File: rtl/sckgen.sv
// SPI clock divider: sck toggles every baud+1 cycles while en is high;
// rise/fall strobes fire in the cycle before the matching sck edge.
module sckgen (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] baud,
  output logic       sck,
  output logic       sck_rise,
  output logic       sck_fall
);

  logic [7:0] cnt_q, cnt_d;
  logic       sck_q, sck_d;
  logic       tick;

  always_comb begin
    tick  = en && (cnt_q == baud);
    cnt_d = cnt_q;
    sck_d = sck_q;
    if (!en) begin
      cnt_d = 8'd0;
      sck_d = 1'b0;
    end else if (tick) begin
      cnt_d = 8'd0;
      sck_d = ~sck_q;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 8'd0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

  assign sck      = sck_q;
  assign sck_rise = tick & ~sck_q;
  assign sck_fall = tick & sck_q;

endmodule

// File: rtl/spi_xfer_ctrl.sv
// Mode-0 SPI master transfer sequencer: drives cs_n, gates one sckgen for
// DATA_W clock periods, shifts MSB first and reports the received word.
module spi_xfer_ctrl
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              hold_cs,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [7:0]        baudrate,
  input  logic              miso,
  output logic              mosi,
  output logic              sck,
  output logic              cs_n,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  xfer_state_e       state_q, state_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]        baud_q, baud_d;
  logic              hold_q, hold_d;
  logic              cs_n_q, cs_n_d;
  logic              sck_en, sck_rise, sck_fall;

  sckgen u_sckgen (
    .clk      (clk),
    .rst      (rst),
    .en       (sck_en),
    .baud     (baud_q),
    .sck      (sck),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall)
  );

  always_comb begin
    state_d   = state_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    bit_cnt_d = bit_cnt_q;
    baud_d    = baud_q;
    hold_d    = hold_q;
    cs_n_d    = cs_n_q;
    sck_en    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          tx_sr_d   = tx_data;
          baud_d    = baudrate;
          hold_d    = hold_cs;
          bit_cnt_d = '0;
          cs_n_d    = 1'b0;
          state_d   = LEAD;
        end
      end
      LEAD: begin
        busy    = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        busy   = 1'b1;
        sck_en = 1'b1;
        if (sck_rise) begin
          rx_sr_d = {rx_sr_q[DATA_W-2:0], miso};
        end
        // Leaving SHIFT on the last fall drops en so sck parks low.
        if (sck_fall) begin
          tx_sr_d   = {tx_sr_q[DATA_W-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d = TRAIL;
          end
        end
      end
      TRAIL: begin
        busy      = 1'b1;
        rx_data_d = rx_sr_q;
        state_d   = DONE;
      end
      DONE: begin
        done    = 1'b1;
        cs_n_d  = ~hold_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      bit_cnt_q <= '0;
      baud_q    <= 8'd0;
      hold_q    <= 1'b0;
      cs_n_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      bit_cnt_q <= bit_cnt_d;
      baud_q    <= baud_d;
      hold_q    <= hold_d;
      cs_n_q    <= cs_n_d;
    end
  end

  assign mosi    = busy ? tx_sr_q[DATA_W-1] : 1'b0;
  assign cs_n    = cs_n_q;
  assign rx_data = rx_data_q;

endmodule

// File: doc/spi_xfer_ctrl.md
# spi_xfer_ctrl

SPI master transfer controller that sequences one `sckgen` instance into complete mode-0 byte transfers. It accepts a start/data handshake from the register interface, drives chip select, enables `sckgen` for exactly DATA_W clock periods, shifts MOSI out and MISO in on the `sck_fall`/`sck_rise` strobes, then returns the received word with a done pulse. It sits between the SPI register block and the pads.

## Interface
- DATA_W, 8, bits per transfer; MSB first
- clk  in  1  system clock; all logic on posedge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request a transfer; sampled only in IDLE
- hold_cs  in  1  sampled with `start`; 1 = keep `cs_n` low after this transfer, for bursts
- tx_data  in  DATA_W  word to send; captured when `start` is accepted
- baudrate  in  8  `sckgen` divider; captured when `start` is accepted
- miso  in  1  serial input
- mosi  out  1  serial output
- sck  out  1  SPI clock, passed through from `sckgen`
- cs_n  out  1  chip select, active low
- busy  out  1  high while a transfer is in progress
- done  out  1  one-cycle pulse when `rx_data` is updated
- rx_data  out  DATA_W  last received word; held until the next `done`

## Operation
- `sckgen` contract relied on:
  - `en=0` forces `sck` low and clears its divider.
  - With `en=1`, `sck` toggles every `baudrate+1` clk cycles.
  - `sck_rise` / `sck_fall` are one-cycle pulses in the cycle before the corresponding `sck` edge.
- States: IDLE, LEAD, SHIFT, TRAIL, DONE.
- IDLE:
  - `start=1` captures `tx_data`→`tx_sr`, `baudrate`→`baud_q`, `hold_cs`→`hold_q`.
  - Clears `bit_cnt` and goes to LEAD.
  - `start=0` stays in IDLE.
- LEAD (1 cycle): `cs_n=0`; `mosi=tx_sr[MSB]`; `en=0`. Goes to SHIFT.
- SHIFT: `en=1`.
  - On `sck_rise`: `rx_sr <= {rx_sr[DATA_W-2:0], miso}`.
  - On `sck_fall`: `tx_sr` shifts left and `bit_cnt` increments.
  - The fall with `bit_cnt == DATA_W-1` goes to TRAIL; `en` drops the same cycle, so `sck` stays low after its last falling edge.
- TRAIL (1 cycle): `en=0`; `cs_n` stays low. Goes to DONE.
- DONE (1 cycle):
  - `rx_data <= rx_sr`; `done=1`.
  - `cs_n <= hold_q ? 0 : 1`.
  - Goes to IDLE.
- `mosi` is `tx_sr[DATA_W-1]` in LEAD/SHIFT/TRAIL and 0 elsewhere.
- Burst: with `hold_cs=1`, `cs_n` stays low through IDLE until the next transfer's DONE with `hold_cs=0`.
- `busy` is high in LEAD/SHIFT/TRAIL and low in IDLE/DONE.
- `start` is ignored outside IDLE; no queuing.
- A `baudrate` change mid-transfer has no effect; `baud_q` drives `sckgen`.
- `bit_cnt` width is `$clog2(DATA_W)+1`; it never wraps inside a transfer.

## Timing
- Reset values:
  - `cs_n=1`, `mosi=0`, `sck=0`, `busy=0`, `done=0`, `rx_data=0`.
  - State IDLE; shift registers, `bit_cnt`, `baud_q` and `hold_q` all 0.
- `start` accepted at edge N:
  - `busy`=1 and `cs_n`=0 from N+1.
  - First `sck` rise at N+2+(B+1), where B = captured `baudrate`.
  - `done` pulse at N+3+2·DATA_W·(B+1).
  - `busy` drops in the cycle `done` rises.
- Earliest back-to-back: `start` held high is re-accepted the cycle after DONE.
- `start` and `sck_rise` in the same cycle cannot collide, because `start` is only sampled in IDLE.
- Reset mid-transfer:
  - Asynchronous return to reset values.
  - `cs_n` goes high immediately.
  - No `done` pulse; `rx_data` clears to 0.

## Structure
- Shared package `spi_pkg`:
  - state encoding localparams (IDLE=0 … DONE=4)
  - `SPI_DATA_W=8`
  - mode-0 CPOL/CPHA constants, for future mode support
- Sub-modules: one `sckgen` instance, which is the natural reuse.
- No other sub-modules; FSM, shift registers and counter are flat, about 150–200 lines.

## Test plan
- Reset then `start` with `tx_data`=0xA5, `baudrate`=0, `miso` looped from `mosi` → `rx_data`=0xA5, one `done` pulse, exactly 8 `sck` rises, `cs_n` high after DONE.
- `tx_data`=0x3C, `miso` tied 1, `baudrate`=3 → `rx_data`=0xFF; `sck` period 8 clk; `done` 3+16·4=67 cycles after `start` accepted.
- `start` re-pulsed during SHIFT with `tx_data`=0x00 → ignored; original 0x5A shifts out unchanged; only one `done`.
- Burst: 0x12 with `hold_cs`=1, then 0x34 with `hold_cs`=0 → `cs_n` low continuously across both; 16 `sck` rises; `cs_n` high after the second `done`.
- `rst` asserted on the 4th `sck` rise of a transfer → `cs_n`=1, `sck`=0, `busy`=0 asynchronously; no `done`; a subsequent transfer of 0xC3 completes correctly.
- `baudrate` changed 1→7 mid-transfer → `sck` period stays 4 clk until `done`; the next transfer uses period 16.
